// File: rtl/tpu_scheduler.sv
// tpu_scheduler: accepts TPU commands from two requesters with round-robin
// arbitration, queues them in a small FIFO and issues them one at a time to
// the TPU. Each issue is a single-cycle execute strobe, after which the
// scheduler waits for the TPU busy flag to fall.
//
// State    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no command in flight; pop and strobe when FIFO non-empty
//          | and TPU not busy
// S_ISSUED | strobe cycle; TPU samples execute at the end of this cycle
// S_SETTLE | one cycle for the TPU to raise busy; opcodes it ignores
//          | never do, so fall back to S_IDLE instead of hanging
// S_WAIT   | TPU busy; hold until it drops
module tpu_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_WIDTH  = 48,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req0_valid,
  input  logic [CMD_WIDTH-1:0] i_req0_command,
  output logic                 o_req0_ready,
  input  logic                 i_req1_valid,
  input  logic [CMD_WIDTH-1:0] i_req1_command,
  output logic                 o_req1_ready,
  output logic                 o_tpu_execute,
  output logic [CMD_WIDTH-1:0] o_tpu_command,
  input  logic                 i_tpu_busy,
  output logic [AW:0]          o_fifo_level,
  output logic                 o_idle,
  output logic [15:0]          o_issued_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUED, S_SETTLE, S_WAIT} state_t;

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

  state_t               r_state;
  logic [CMD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_level;
  logic                 r_last_grant;
  logic                 r_tpu_execute;
  logic [CMD_WIDTH-1:0] r_tpu_command;
  logic [15:0]          r_issued_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_grant0;
  logic                 w_grant1;
  logic                 w_push;
  logic                 w_pop;
  logic [CMD_WIDTH-1:0] w_push_cmd;

  assign w_full  = (r_level == LEVEL_FULL);
  assign w_empty = (r_level == '0);

  // Round-robin grant: a lone requester always wins; on a tie the one not
  // granted last time wins (r_last_grant resets to 1 so req0 wins first).
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = !r_last_grant;
    end else begin
      w_grant0 = i_req0_valid;
      w_grant1 = i_req1_valid;
    end
  end

  assign o_req0_ready = w_grant0 && !w_full;
  assign o_req1_ready = w_grant1 && !w_full;
  assign w_push       = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
  assign w_push_cmd   = w_grant1 ? i_req1_command : i_req0_command;
  // Pop only from committed entries, so a push is never issuable in its own cycle.
  assign w_pop        = (r_state == S_IDLE) && !w_empty && !i_tpu_busy;

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_cmd;
  end

  // FIFO pointers, fill level and the arbiter's last-granted requester.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_last_grant <= w_grant1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue FSM with registered strobe, command and issue counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_tpu_execute  <= 1'b0;
      r_tpu_command  <= '0;
      r_issued_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tpu_execute <= 1'b0;
          if (w_pop) begin
            r_tpu_command  <= r_mem[r_rd_ptr];
            r_tpu_execute  <= 1'b1;
            r_issued_count <= r_issued_count + 16'd1;
            r_state        <= S_ISSUED;
          end
        end
        S_ISSUED: begin
          r_tpu_execute <= 1'b0;
          r_state       <= S_SETTLE;
        end
        S_SETTLE: begin
          r_tpu_execute <= 1'b0;
          r_state       <= i_tpu_busy ? S_WAIT : S_IDLE;
        end
        S_WAIT: begin
          r_tpu_execute <= 1'b0;
          if (!i_tpu_busy) r_state <= S_IDLE;
        end
        default: begin
          r_tpu_execute <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tpu_execute  = r_tpu_execute;
  assign o_tpu_command  = r_tpu_command;
  assign o_issued_count = r_issued_count;
  assign o_fifo_level   = r_level;
  assign o_idle         = (r_state == S_IDLE) && w_empty && !i_tpu_busy;

endmodule

// File: tb/tb_tpu_scheduler.sv
// Directed testbench for tpu_scheduler: reset state, single command, fairness,
// full FIFO back-pressure, ignored opcodes, busy gating and mid-command reset.
module tb_tpu_scheduler;
  localparam int CW = 48;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0v = 1'b0, r1v = 1'b0, busy = 1'b0;
  logic [CW-1:0] r0c = '0, r1c = '0;
  logic          rdy0, rdy1, exec, idle;
  logic [CW-1:0] cmd;
  logic [2:0]    level;
  logic [15:0]   issued;

  tpu_scheduler #(.FIFO_DEPTH(4), .CMD_WIDTH(CW)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_req0_valid   (r0v),
    .i_req0_command (r0c),
    .o_req0_ready   (rdy0),
    .i_req1_valid   (r1v),
    .i_req1_command (r1c),
    .o_req1_ready   (rdy1),
    .o_tpu_execute  (exec),
    .o_tpu_command  (cmd),
    .i_tpu_busy     (busy),
    .o_fifo_level   (level),
    .o_idle         (idle),
    .o_issued_count (issued)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] mk(input int r, input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'h0000, (r != 0) ? 8'hB0 : 8'hA0, kk, 8'h02};
  endfunction

  // Strobe monitor: records every issued command with its cycle number.
  int            cyc = 0;
  logic          prev_exec = 1'b0;
  logic [CW-1:0] q_cmd [$];
  int            q_cyc [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    chk("exec_single_cycle", prev_exec & exec, 1'b0);
    if (exec) begin
      q_cmd.push_back(cmd);
      q_cyc.push_back(cyc);
    end
    prev_exec <= exec;
  end

  task automatic wait_idle(input int lim, input string tag);
    int c = 0;
    while (!idle && c < lim) begin
      step();
      c++;
    end
    chk(tag, c < lim, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, k0, k1;
    logic a0, a1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_exec", exec, 1'b0);
    chk("rst_cmd", cmd, 48'h0);
    chk("rst_level", level, 3'd0);
    chk("rst_issued", issued, 16'd0);
    chk("rst_idle", idle, 1'b1);
    step();
    rst_n = 1'b1;

    // Single command, TPU busy for 2 cycles
    r0v = 1'b1; r0c = 48'h0000_0000_4102;
    @(negedge clk);
    chk("t1_ready0", rdy0, 1'b1);
    chk("t1_ready1", rdy1, 1'b0);
    step(); r0v = 1'b0;
    @(negedge clk);
    chk("t1_level", level, 3'd1);
    chk("t1_exec_early", exec, 1'b0);
    chk("t1_not_idle", idle, 1'b0);
    step();
    @(negedge clk);
    chk("t1_exec", exec, 1'b1);
    chk("t1_cmd", cmd, 48'h0000_0000_4102);
    chk("t1_issued", issued, 16'd1);
    chk("t1_level_pop", level, 3'd0);
    step(); busy = 1'b1;
    @(negedge clk);
    chk("t1_exec_drop", exec, 1'b0);
    chk("t1_cmd_hold", cmd, 48'h0000_0000_4102);
    step();
    @(negedge clk);
    chk("t1_busy_idle", idle, 1'b0);
    step(); busy = 1'b0;
    @(negedge clk);
    chk("t1_wait_idle", idle, 1'b0);
    step();
    @(negedge clk);
    chk("t1_idle", idle, 1'b1);
    chk("t1_nstrobe", q_cmd.size(), 1);

    // Fairness: both requesters continuously valid from a fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    q_cmd.delete(); q_cyc.delete();
    acc = 0; k0 = 0; k1 = 0;
    r0v = 1'b1; r0c = mk(0, 0);
    r1v = 1'b1; r1c = mk(1, 0);
    for (int c = 0; c < 100 && acc < 8; c++) begin
      @(negedge clk);
      a0 = rdy0; a1 = rdy1;
      if (a0 | a1) begin
        chk("fair_grant", {a1, a0}, (acc % 2 != 0) ? 2'b10 : 2'b01);
        acc++;
      end
      step();
      if (a0) begin k0++; r0c = mk(0, k0); end
      if (a1) begin k1++; r1c = mk(1, k1); end
    end
    r0v = 1'b0; r1v = 1'b0;
    chk("fair_accepts", acc, 8);
    wait_idle(200, "fair_drain");
    chk("fair_nissued", q_cmd.size(), 8);
    for (int i = 0; i < 8; i++)
      chk("fair_order", (i < q_cmd.size()) ? q_cmd[i] : 48'h0, mk(i % 2, i / 2));
    chk("fair_count", issued, 16'd8);

    // Full FIFO with TPU busy held high
    q_cmd.delete(); q_cyc.delete();
    busy = 1'b1; r0v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0c = mk(0, 16 + i);
      @(negedge clk);
      chk("full_accept", rdy0, 1'b1);
      step();
    end
    r0c = mk(0, 20); r1v = 1'b1; r1c = mk(1, 32);
    @(negedge clk);
    chk("full_level", level, 3'd4);
    chk("full_ready0", rdy0, 1'b0);
    chk("full_ready1", rdy1, 1'b0);
    step(); r1v = 1'b0; busy = 1'b0;
    @(negedge clk);
    chk("full_still_blocked", rdy0, 1'b0);
    chk("full_no_exec", exec, 1'b0);
    step();
    @(negedge clk);
    chk("full_pop_exec", exec, 1'b1);
    chk("full_level_pop", level, 3'd3);
    chk("full_fifth_ready", rdy0, 1'b1);
    step(); r0v = 1'b0;
    @(negedge clk);
    chk("full_level_refill", level, 3'd4);
    wait_idle(200, "full_drain");
    chk("full_nissued", q_cmd.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("full_order", (i < q_cmd.size()) ? q_cmd[i] : 48'h0, mk(0, 16 + i));
    chk("full_count", issued, 16'd13);

    // Ignored opcode 0xFF: busy never rises, strobes 3 cycles apart
    q_cmd.delete(); q_cyc.delete();
    r0v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r0c = {40'hC0_0000_0000 + 40'(i), 8'hFF};
      step();
    end
    r0v = 1'b0;
    wait_idle(100, "ign_drain");
    chk("ign_nissued", q_cmd.size(), 3);
    if (q_cyc.size() == 3) begin
      chk("ign_gap01", q_cyc[1] - q_cyc[0], 3);
      chk("ign_gap12", q_cyc[2] - q_cyc[1], 3);
      chk("ign_cmd2", q_cmd[2], {40'hC0_0000_0002, 8'hFF});
    end
    chk("ign_count", issued, 16'd16);

    // Busy gating
    q_cmd.delete(); q_cyc.delete();
    busy = 1'b1; r0v = 1'b1; r0c = mk(0, 48);
    step(); r0v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gate_no_exec", exec, 1'b0);
      step();
    end
    busy = 1'b0;
    @(negedge clk);
    chk("gate_release_cycle", exec, 1'b0);
    step();
    @(negedge clk);
    chk("gate_exec", exec, 1'b1);
    chk("gate_cmd", cmd, mk(0, 48));
    wait_idle(50, "gate_drain");
    chk("gate_count", issued, 16'd17);

    // Reset while waiting on a busy TPU with 3 commands queued
    q_cmd.delete(); q_cyc.delete();
    r0v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r0c = mk(0, 64 + i);
      if (i == 3) busy = 1'b1;
      step();
    end
    r0v = 1'b0;
    @(negedge clk);
    chk("mid_level", level, 3'd3);
    chk("mid_cmd", cmd, mk(0, 64));
    chk("mid_count", issued, 16'd18);
    chk("mid_not_idle", idle, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_exec", exec, 1'b0);
    chk("mid_rst_cmd", cmd, 48'h0);
    chk("mid_rst_level", level, 3'd0);
    chk("mid_rst_count", issued, 16'd0);
    chk("mid_rst_busy_idle", idle, 1'b0);
    busy = 1'b0;
    #1;
    chk("mid_rst_idle", idle, 1'b1);
    step(); step();
    rst_n = 1'b1;
    q_cmd.delete(); q_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", exec, 1'b0);
      step();
    end
    chk("post_rst_nissued", q_cmd.size(), 0);
    chk("post_rst_level", level, 3'd0);
    r0v = 1'b1; r0c = mk(0, 80);
    step(); r0v = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_exec", exec, 1'b1);
    chk("post_rst_cmd", cmd, mk(0, 80));
    chk("post_rst_count", issued, 16'd1);
    wait_idle(50, "post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
